// File: rtl/skid_buf_pkg.sv
// Shared types and constants for the skid buffer.
package skid_buf_pkg;

  localparam int SKID_BUF_DEPTH = 2;
  localparam int OCC_W = $clog2(SKID_BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

  // Number of entries held in each state.
  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      BUSY:    occ_of = OCC_W'(1);
      FULL:    occ_of = OCC_W'(2);
      default: occ_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/skid_reg.sv
// WIDTH-bit data register with synchronous reset and load enable.
module skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = en ? d : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/skid_buf.sv
// Two-entry skid buffer with fully registered i_ready/q_valid.
// Define SKID_BUF_OCC_EN to add the registered occupancy output occ.
module skid_buf
  import skid_buf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready
`ifdef SKID_BUF_OCC_EN
  ,
  output logic [1:0]       occ
`endif
);

  state_e           state_q, state_d;
  logic             q_valid_q, q_valid_d;
  logic             i_ready_q, i_ready_d;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             in_xfer, out_xfer;

  assign in_xfer  = i_valid & i_ready_q;
  assign out_xfer = q_valid_q & q_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_en = 1'b1;
        end
      end
      BUSY: begin
        case ({in_xfer, out_xfer})
          2'b10: begin
            state_d = FULL;
            skid_en = 1'b1;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   main_en = 1'b1;
          default: ;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          state_d        = BUSY;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Handshake flags are computed from the next state so they leave as plain flops.
    q_valid_d = (state_d != EMPTY);
    i_ready_d = (state_d != FULL);
    main_d    = main_from_skid ? skid_q : i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      q_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      q_valid_q <= q_valid_d;
      i_ready_q <= i_ready_d;
    end
  end

  skid_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  skid_reg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (i),
    .q   (skid_q)
  );

  assign q       = main_q;
  assign q_valid = q_valid_q;
  assign i_ready = i_ready_q;

`ifdef SKID_BUF_OCC_EN
  logic [1:0] occ_q;

  always_ff @(posedge clk) begin
    if (rst) occ_q <= 2'd0;
    else     occ_q <= occ_of(state_d);
  end

  assign occ = occ_q;
`endif

endmodule

// File: tb/tb_skid_buf.sv
// Directed and randomized self-checking bench for skid_buf.
module tb_skid_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] i = 8'h00;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready = 1'b0;
`ifdef SKID_BUF_OCC_EN
  logic [1:0] occ;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic [7:0] expv, held;
  logic       in_x, out_x, stalled;
  int         outs, cycles;

  always #5 clk = ~clk;

  skid_buf #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready)
`ifdef SKID_BUF_OCC_EN
    ,
    .occ     (occ)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    i_valid = v;
    i       = d;
    q_ready = r;
  endtask

  task automatic check_occ(input string tag, input logic [1:0] exp);
`ifdef SKID_BUF_OCC_EN
    check(tag, 64'(occ), 64'(exp));
`else
    if (exp > 2'd2) $display("bad occ expectation %0d for %s", exp, tag);
`endif
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b0;
    check("rst_qvalid", 64'(q_valid), 64'd0);
    check("rst_iready", 64'(i_ready), 64'd1);
    check("rst_q", 64'(q), 64'h00);
    check_occ("rst_occ", 2'd0);

    // Single transfer, one-cycle latency
    drive(1'b1, 8'h5A, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    check("lat_q", 64'(q), 64'h5A);
    check("lat_qvalid", 64'(q_valid), 64'd1);
    step();
    check("lat_drain", 64'(q_valid), 64'd0);

    // Back-to-back stream
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 8'(k), 1'b1);
      step();
      check("stream_q", 64'(q), 64'(k));
      check("stream_qvalid", 64'(q_valid), 64'd1);
      check("stream_iready", 64'(i_ready), 64'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("stream_drain", 64'(q_valid), 64'd0);

    // Fill to FULL, refuse third word, drain in order
    drive(1'b1, 8'hA1, 1'b0);
    step();
    check("full_first", 64'(q), 64'hA1);
    drive(1'b1, 8'hA2, 1'b0);
    step();
    check("full_iready", 64'(i_ready), 64'd0);
    check("full_q", 64'(q), 64'hA1);
    check("full_qvalid", 64'(q_valid), 64'd1);
    check_occ("full_occ", 2'd2);
    drive(1'b1, 8'hA3, 1'b0);
    step();
    check("full_hold_q", 64'(q), 64'hA1);
    check("full_hold_iready", 64'(i_ready), 64'd0);
    drive(1'b1, 8'hA3, 1'b1);
    step();
    check("drain_a2", 64'(q), 64'hA2);
    check("drain_iready", 64'(i_ready), 64'd1);
    check_occ("drain_occ", 2'd1);
    step();
    check("drain_a3", 64'(q), 64'hA3);
    check("drain_a3_valid", 64'(q_valid), 64'd1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("drain_empty", 64'(q_valid), 64'd0);

    // Simultaneous in/out while BUSY
    drive(1'b1, 8'h11, 1'b0);
    step();
    check("busy_q11", 64'(q), 64'h11);
    drive(1'b1, 8'h22, 1'b1);
    step();
    check("busy_q22", 64'(q), 64'h22);
    check("busy_qvalid", 64'(q_valid), 64'd1);
    check("busy_iready", 64'(i_ready), 64'd1);
    check_occ("busy_occ", 2'd1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("busy_drain", 64'(q_valid), 64'd0);

    // Reset while FULL discards everything
    drive(1'b1, 8'hB1, 1'b0);
    step();
    drive(1'b1, 8'hB2, 1'b0);
    step();
    check("prerst_full", 64'(i_ready), 64'd0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    step();
    rst = 1'b0;
    check("midrst_qvalid", 64'(q_valid), 64'd0);
    check("midrst_iready", 64'(i_ready), 64'd1);
    check("midrst_q", 64'(q), 64'h00);
    check_occ("midrst_occ", 2'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("postrst_qvalid", 64'(q_valid), 64'd0);
    end
    drive(1'b1, 8'hC1, 1'b1);
    step();
    check("postrst_q", 64'(q), 64'hC1);
    drive(1'b0, 8'h00, 1'b1);
    step();
    check("postrst_drain", 64'(q_valid), 64'd0);

    // Random handshake against a FIFO scoreboard
    outs   = 0;
    cycles = 0;
    while (outs < 10000 && cycles < 60000 && failures <= 20) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      check("rnd_qvalid", 64'(q_valid), 64'(sb.size() != 0));
      check("rnd_iready", 64'(i_ready), 64'(sb.size() < 2));
      in_x  = i_valid && i_ready;
      out_x = q_valid && q_ready;
      if (out_x) begin
        expv = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
        check("rnd_data", 64'(q), 64'(expv));
        outs++;
      end
      stalled = q_valid && !q_ready;
      held    = q;
      if (in_x) sb.push_back(i);
      step();
      cycles++;
      if (stalled) begin
        check("rnd_hold_q", 64'(q), 64'(held));
        check("rnd_hold_valid", 64'(q_valid), 64'd1);
      end
    end
    check("rnd_transfers", 64'(outs), 64'd10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/skid_buf.md
SKID_BUF -- requirements
Module: skid_buf

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data path width in bits (legal range 1..64).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port i, input, WIDTH, SHALL carry upstream data.
REQ-005 Port i_valid, input, 1, SHALL mark i as valid.
REQ-006 Port i_ready, output, 1, SHALL indicate that the block accepts i this cycle.
REQ-007 Port q, output, WIDTH, SHALL carry data to the downstream driver stage.
REQ-008 Port q_valid, output, 1, SHALL mark q as valid.
REQ-009 Port q_ready, input, 1, SHALL indicate that downstream accepts q this cycle.

Function
REQ-010 An input transfer SHALL occur on an edge where i_valid=1 and i_ready=1; an output transfer SHALL occur where q_valid=1 and q_ready=1.
REQ-011 The FSM SHALL have three states: EMPTY (0 entries), BUSY (1 entry in the main register), FULL (main and skid registers both occupied).
REQ-012 EMPTY: input transfer -> BUSY; otherwise stay.
REQ-013 BUSY: input without output -> FULL (data to skid); output without input -> EMPTY; both -> BUSY with main reloaded from i; neither -> stay.
REQ-014 FULL: output transfer -> BUSY with main loaded from skid; otherwise stay; i_ready=0, so no input transfer is possible.
REQ-015 q_valid SHALL be 1 in BUSY and FULL, and i_ready SHALL be 1 in EMPTY and BUSY; both SHALL be direct register outputs with no combinational path from i_valid or q_ready.
REQ-016 Latency from input transfer to q_valid SHALL be exactly 1 cycle when EMPTY.
REQ-017 Throughput SHALL be 1 transfer/cycle when q_ready is held at 1.
REQ-018 Data SHALL emerge in strict FIFO order with no loss or duplication.
REQ-019 q SHALL hold its value while q_valid=1 and q_ready=0.
REQ-020 i SHALL be ignored whenever i_ready=0 or i_valid=0.

Reset
REQ-021 While rst=1 at a clock edge, state SHALL become EMPTY, q_valid SHALL become 0, and i_ready SHALL become 1 on the following cycle.
REQ-022 q SHALL reset to all-zero, and the skid register SHALL reset to all-zero.
REQ-023 Reset mid-operation SHALL discard all held data; no transfer SHALL be reported in the reset cycle.

Configuration
REQ-024 Macro SKID_BUF_OCC_EN, when defined, SHALL add output port occ [1:0], equal to the number of held entries (EMPTY=0, BUSY=1, FULL=2), registered, and reset to 0.
REQ-025 Without SKID_BUF_OCC_EN, port occ SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package skid_buf_pkg SHALL hold the state typedef (EMPTY/BUSY/FULL, 2-bit encoding 00/01/10) and the constant SKID_BUF_DEPTH=2.
REQ-027 One sub-module, skid_reg (WIDTH-bit register with synchronous reset and load enable), SHALL be instantiated twice, for main and skid.

Verification
REQ-028 Reset, then i=0x5A, i_valid=1 for one cycle, q_ready=1 -> next cycle q=0x5A, q_valid=1; one cycle later q_valid=0.
REQ-029 Stream 0x01..0x10 back-to-back with q_ready=1 -> outputs 0x01..0x10 on consecutive cycles, i_ready constantly 1.
REQ-030 q_ready=0, push 0xA1 then 0xA2 -> FULL, i_ready=0, q=0xA1 held; 0xA3 presented is not accepted; then q_ready=1 -> 0xA1, 0xA2, 0xA3 in order.
REQ-031 In BUSY with q=0x11, simultaneous input 0x22 and output transfer -> next cycle q=0x22, state BUSY, occ=1 (if SKID_BUF_OCC_EN).
REQ-032 In FULL, assert rst for one cycle -> q_valid=0, i_ready=1, q=0x00, occ=0; previously held data never appears on q.
REQ-033 Random i_valid/q_ready (50% each, 10k transfers) -> scoreboard matches in order; q stable whenever stalled.
